// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/occupancy controller:
// default geometry, threshold constants, level-width helper and the
// elaboration-time parameter check.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

package fifo_pkg;

   localparam int FIFO_DEF_ADDR_W = 4;
   localparam int FIFO_DEF_DEPTH  = 16;
   localparam int FIFO_DEF_AFULL  = 14;
   localparam int FIFO_DEF_AEMPTY = 2;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int fifo_lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// Halts elaboration when a parameter set is not legal.
`define FIFO_PARAM_CHECK(ok, msg) \
   if (!(ok)) begin : g_param_check \
      $fatal(1, msg); \
   end

`endif

// File: rtl/wrap_counter.sv
// Modulo-LIMIT counter used for the RAM write and read addresses.
// Counts 0..LIMIT-1 and never holds a value >= LIMIT.
module wrap_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // Advance on inc, wrapping from LIMIT-1 back to 0; reset and clear zero it.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc) begin
         count <= (count == LAST) ? '0 : count + ONE;
      end
   end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and occupancy controller for a single-clock RAM FIFO.
// Accepts push/pop requests, produces RAM addresses and enables, and keeps
// the fill level plus registered full/empty/almost flags and sticky errors.
//
// Handshake: wr_en/rd_en are combinational acceptances of push/pop. A push
// is accepted when not full, or when full and a pop is accepted alongside.
// A pop is accepted only when not empty (the RAM is read-before-write, so a
// same-cycle push cannot satisfy it). clear suppresses both.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W     = FIFO_DEF_ADDR_W,
   parameter int DEPTH      = FIFO_DEF_DEPTH,
   parameter int AFULL_LVL  = FIFO_DEF_AFULL,
   parameter int AEMPTY_LVL = FIFO_DEF_AEMPTY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              clear,
   input  logic              err_clr,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int LVL_W = fifo_lvl_w(DEPTH);

   `FIFO_PARAM_CHECK((DEPTH >= 2) && (DEPTH <= (1 << ADDR_W)) &&
                     (AFULL_LVL >= 1) && (AFULL_LVL <= DEPTH) &&
                     (AEMPTY_LVL >= 0) && (AEMPTY_LVL < DEPTH) &&
                     (LVL_W <= ADDR_W + 1),
                     "fifo_ptr_ctrl: illegal parameter set")

   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W + 1)'(AFULL_LVL);
   localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W + 1)'(AEMPTY_LVL);
   localparam logic [ADDR_W:0] ONE_L    = (ADDR_W + 1)'(1);

   logic [ADDR_W:0] level_nxt;

   // Acceptance and next occupancy; clear wins over any request.
   always_comb begin
      rd_en     = pop & ~empty & ~clear;
      wr_en     = push & (~full | pop) & ~clear;
      level_nxt = level;
      if (clear) begin
         level_nxt = '0;
      end else if (wr_en && !rd_en) begin
         level_nxt = level + ONE_L;
      end else if (rd_en && !wr_en) begin
         level_nxt = level - ONE_L;
      end
   end

   // Level and flags registered together from the next level, so no flag lags.
   always_ff @(posedge clock) begin
      if (reset) begin
         level        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         level        <= level_nxt;
         full         <= (level_nxt == DEPTH_L);
         empty        <= (level_nxt == '0);
         almost_full  <= (level_nxt >= AFULL_L);
         almost_empty <= (level_nxt <= AEMPTY_L);
      end
   end

   // Sticky rejection errors; a new rejection beats err_clr, clear leaves them.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (push && !wr_en && !clear) begin
            overflow <= 1'b1;
         end
         if (pop && !rd_en && !clear) begin
            underflow <= 1'b1;
         end
      end
   end

   wrap_counter #(
      .WIDTH (ADDR_W),
      .LIMIT (DEPTH)
   ) u_wr_ptr (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .inc   (wr_en),
      .count (wr_ptr)
   );

   wrap_counter #(
      .WIDTH (ADDR_W),
      .LIMIT (DEPTH)
   ) u_rd_ptr (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .inc   (rd_en),
      .count (rd_ptr)
   );

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: a DEPTH=16 instance for fill/drain,
// errors, clear and reset, plus a DEPTH=12 instance for non-power-of-two wrap.
module tb_fifo_ptr_ctrl;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // ---------------- DEPTH=16 instance ----------------
   logic       push = 1'b0, pop = 1'b0, clear = 1'b0, err_clr = 1'b0;
   logic       wr_en, rd_en, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] wr_ptr, rd_ptr;
   logic [4:0] level;

   fifo_ptr_ctrl #(
      .ADDR_W(4), .DEPTH(16), .AFULL_LVL(14), .AEMPTY_LVL(2)
   ) u_dut (
      .clock(clock), .reset(reset), .push(push), .pop(pop), .clear(clear),
      .err_clr(err_clr), .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr),
      .rd_ptr(rd_ptr), .level(level), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow)
   );

   // ---------------- DEPTH=12 instance ----------------
   logic       push2 = 1'b0, pop2 = 1'b0, clear2 = 1'b0, err_clr2 = 1'b0;
   logic       wr_en2, rd_en2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
   logic [3:0] wr_ptr2, rd_ptr2;
   logic [4:0] level2;

   fifo_ptr_ctrl #(
      .ADDR_W(4), .DEPTH(12), .AFULL_LVL(10), .AEMPTY_LVL(2)
   ) u_dut12 (
      .clock(clock), .reset(reset), .push(push2), .pop(pop2), .clear(clear2),
      .err_clr(err_clr2), .wr_en(wr_en2), .rd_en(rd_en2), .wr_ptr(wr_ptr2),
      .rd_ptr(rd_ptr2), .level(level2), .full(full2), .empty(empty2),
      .almost_full(almost_full2), .almost_empty(almost_empty2),
      .overflow(overflow2), .underflow(underflow2)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   // Combinational outputs captured mid-cycle, before the active edge.
   logic       s_wr_en, s_rd_en, s_wr_en2, s_rd_en2;
   logic [3:0] s_wr_ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int lv, input int wp, input int rp,
                          input logic f, input logic e, input logic af, input logic ae,
                          input logic ov, input logic un);
      chk({tag, ".level"},        32'(level),        32'(lv));
      chk({tag, ".wr_ptr"},       32'(wr_ptr),       32'(wp));
      chk({tag, ".rd_ptr"},       32'(rd_ptr),       32'(rp));
      chk({tag, ".full"},         32'(full),         32'(f));
      chk({tag, ".empty"},        32'(empty),        32'(e));
      chk({tag, ".almost_full"},  32'(almost_full),  32'(af));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
      chk({tag, ".overflow"},     32'(overflow),     32'(ov));
      chk({tag, ".underflow"},    32'(underflow),    32'(un));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic p, input logic po, input logic cl, input logic ec);
      @(negedge clock);
      push = p; pop = po; clear = cl; err_clr = ec;
      #1;
      s_wr_en  = wr_en;
      s_rd_en  = rd_en;
      s_wr_ptr = wr_ptr;
      @(posedge clock);
      #1;
      push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0;
   endtask

   task automatic cycle12(input logic p, input logic po);
      @(negedge clock);
      push2 = p; pop2 = po;
      #1;
      s_wr_en2 = wr_en2;
      s_rd_en2 = rd_en2;
      @(posedge clock);
      #1;
      push2 = 1'b0; pop2 = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int exp_w;
      int exp_r;

      // Reset values
      @(posedge clock);
      @(posedge clock);
      #1;
      chk_all("reset", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Fill to 16; almost_full from level 14, full at 16, wr_ptr wraps to 0
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         chk("fill.wr_en", 32'(s_wr_en), 32'd1);
         chk("fill.level", 32'(level), 32'(i));
         chk("fill.almost_full", 32'(almost_full), 32'(i >= 14));
         chk("fill.full", 32'(full), 32'(i == 16));
      end
      chk_all("fill", 16, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Push+pop while full: both accepted, level holds, no overflow
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      chk("full_pp.wr_en", 32'(s_wr_en), 32'd1);
      chk("full_pp.rd_en", 32'(s_rd_en), 32'd1);
      chk_all("full_pp", 16, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Push while full without pop: rejected, overflow sticks
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("ovf.wr_en", 32'(s_wr_en), 32'd0);
      chk_all("ovf", 16, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovf_hold.overflow", 32'(overflow), 32'd1);
      // err_clr together with a fresh overflow: set wins
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("ovf_vs_clr.overflow", 32'(overflow), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("err_clr.overflow", 32'(overflow), 32'd0);

      // Drain 16; almost_empty at level <= 2; rd_ptr started at 1 so ends at 1
      for (int i = 15; i >= 0; i--) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         chk("drain.rd_en", 32'(s_rd_en), 32'd1);
         chk("drain.level", 32'(level), 32'(i));
         chk("drain.almost_empty", 32'(almost_empty), 32'(i <= 2));
         chk("drain.almost_full", 32'(almost_full), 32'(i >= 14));
      end
      chk_all("drain", 0, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Push+pop while empty: pop rejected (no bypass), push accepted
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      chk("empty_pp.rd_en", 32'(s_rd_en), 32'd0);
      chk("empty_pp.wr_en", 32'(s_wr_en), 32'd1);
      chk_all("empty_pp", 1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Build to level 7, then clear with push and pop high
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk_all("lvl7", 7, 8, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      chk("clear.wr_en", 32'(s_wr_en), 32'd0);
      chk("clear.rd_en", 32'(s_rd_en), 32'd0);
      chk_all("clear", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

      // Reset mid-stream at level 9 with requests pending
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_rst.level", 32'(level), 32'd9);
      @(negedge clock);
      reset = 1'b1; push = 1'b1; pop = 1'b1;
      @(posedge clock);
      #1;
      chk_all("mid_reset", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0; push = 1'b0; pop = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst.wr_addr", 32'(s_wr_ptr), 32'd0);
      chk("post_rst.wr_en", 32'(s_wr_en), 32'd1);
      chk_all("post_rst", 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // DEPTH=12: prefill 5, then 30 push/pop pairs wrap both pointers at 11
      for (int i = 0; i < 5; i++) cycle12(1'b1, 1'b0);
      chk("d12.prefill.level", 32'(level2), 32'd5);
      chk("d12.prefill.wr_ptr", 32'(wr_ptr2), 32'd5);
      exp_w = 5;
      exp_r = 0;
      for (int i = 0; i < 30; i++) begin
         cycle12(1'b1, 1'b1);
         exp_w = (exp_w == 11) ? 0 : exp_w + 1;
         exp_r = (exp_r == 11) ? 0 : exp_r + 1;
         chk("d12.pair.wr_en", 32'(s_wr_en2), 32'd1);
         chk("d12.pair.rd_en", 32'(s_rd_en2), 32'd1);
         chk("d12.pair.wr_ptr", 32'(wr_ptr2), 32'(exp_w));
         chk("d12.pair.rd_ptr", 32'(rd_ptr2), 32'(exp_r));
         chk("d12.pair.level", 32'(level2), 32'd5);
      end
      // Top up to 12: full asserts, write pointer keeps wrapping below 12
      for (int i = 0; i < 7; i++) begin
         cycle12(1'b1, 1'b0);
         exp_w = (exp_w == 11) ? 0 : exp_w + 1;
      end
      chk("d12.full.level", 32'(level2), 32'd12);
      chk("d12.full.full", 32'(full2), 32'd1);
      chk("d12.full.almost_full", 32'(almost_full2), 32'd1);
      chk("d12.full.wr_ptr", 32'(wr_ptr2), 32'(exp_w));
      cycle12(1'b1, 1'b0);
      chk("d12.ovf.wr_en", 32'(s_wr_en2), 32'd0);
      chk("d12.ovf.overflow", 32'(overflow2), 32'd1);
      chk("d12.ovf.underflow", 32'(underflow2), 32'd0);
      chk("d12.ovf.empty", 32'(empty2), 32'd0);
      chk("d12.ovf.almost_empty", 32'(almost_empty2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
